// File: rtl/rmii_tx_scheduler.sv
// rtl/rmii_tx_scheduler.sv - round-robin RMII transmit scheduler
// Arbitrates NUM_REQ byte sources, adds preamble/SFD, serialises LSB-first dibits, enforces IFG.
module rmii_tx_scheduler #(
  parameter int NUM_REQ         = 2,
  parameter int IFG_CLKS        = 48,
  parameter int MAX_FRAME_BYTES = 1522
) (
  input  logic                   clk_50MHz,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   busy,
  output logic                   underrun,
  output logic                   truncated,
  output logic                   TX_EN,
  output logic                   TX0,
  output logic                   TX1
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BW = $clog2(MAX_FRAME_BYTES + 1);
  localparam int IW = (IFG_CLKS > 1) ? $clog2(IFG_CLKS) : 1;

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, IFG} state_t;

  state_t             state, state_n;
  logic [4:0]         cnt;
  logic [IW-1:0]      ifg_cnt;
  logic [BW-1:0]      byte_cnt;
  logic [7:0]         byte_q;
  logic               last_q;
  logic [PW-1:0]      ptr, gidx, pick, idx_hi, idx_lo;
  logic               found_hi, found_lo, any_req, fetch;
  logic [NUM_REQ-1:0] pick_oh;
  logic               sel_valid, sel_last, cap_limit;
  logic [7:0]         sel_data;
  logic [1:0]         tx;

  // Requesters above the pointer beat those at or below it, lowest index first in each group.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    idx_hi   = '0;
    idx_lo   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i] && (PW'(i) > ptr)) begin
        found_hi = 1'b1;
        idx_hi   = PW'(i);
      end
      if (req_valid[i] && (PW'(i) <= ptr)) begin
        found_lo = 1'b1;
        idx_lo   = PW'(i);
      end
    end
    pick          = found_hi ? idx_hi : idx_lo;
    any_req       = found_hi | found_lo;
    pick_oh       = '0;
    pick_oh[pick] = 1'b1;
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gidx == PW'(i)) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_data  = req_data[8*i +: 8];
      end
    end
  end

  assign cap_limit = (byte_cnt == BW'(MAX_FRAME_BYTES - 1));

  always_comb begin
    state_n = state;
    fetch   = 1'b0;
    case (state)
      IDLE: if (any_req) state_n = PREAMBLE;
      PREAMBLE: begin
        if (cnt == 5'd31) begin
          fetch   = 1'b1;
          state_n = sel_valid ? DATA : IFG;
        end
      end
      DATA: begin
        if (cnt[1:0] == 2'd3) begin
          if (last_q) begin
            state_n = IFG;
          end else begin
            fetch   = 1'b1;
            state_n = sel_valid ? DATA : IFG;
          end
        end
      end
      default: if (ifg_cnt == IW'(IFG_CLKS - 1)) state_n = IDLE;
    endcase
  end

  assign req_ready = fetch ? grant : '0;
  assign busy      = (state != IDLE);
  assign TX0       = tx[0];
  assign TX1       = tx[1];

  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      state     <= IDLE;
      TX_EN     <= 1'b0;
      tx        <= 2'b00;
      grant     <= '0;
      gidx      <= '0;
      ptr       <= PW'(NUM_REQ - 1);
      underrun  <= 1'b0;
      truncated <= 1'b0;
      cnt       <= '0;
      ifg_cnt   <= '0;
      byte_cnt  <= '0;
      byte_q    <= '0;
      last_q    <= 1'b0;
    end else begin
      state     <= state_n;
      underrun  <= 1'b0;
      truncated <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            grant    <= pick_oh;
            gidx     <= pick;
            ptr      <= pick;
            TX_EN    <= 1'b1;
            tx       <= 2'b01;
            cnt      <= '0;
            byte_cnt <= '0;
          end
        end
        PREAMBLE, DATA: begin
          if (fetch) begin
            if (sel_valid) begin
              byte_q    <= sel_data;
              last_q    <= sel_last | cap_limit;
              truncated <= ~sel_last & cap_limit;
              byte_cnt  <= byte_cnt + 1'b1;
              tx        <= sel_data[1:0];
              cnt       <= '0;
            end else begin
              underrun <= 1'b1;
              TX_EN    <= 1'b0;
              tx       <= 2'b00;
              grant    <= '0;
              ifg_cnt  <= '0;
            end
          end else if (state == DATA && cnt[1:0] == 2'd3) begin
            TX_EN   <= 1'b0;
            tx      <= 2'b00;
            grant   <= '0;
            ifg_cnt <= '0;
          end else begin
            cnt <= cnt + 5'd1;
            // tx is loaded with the dibit that follows the one currently on the wire
            if (state == PREAMBLE) tx <= (cnt == 5'd30) ? 2'b11 : 2'b01;
            else if (cnt[1:0] == 2'd0) tx <= byte_q[3:2];
            else if (cnt[1:0] == 2'd1) tx <= byte_q[5:4];
            else tx <= byte_q[7:6];
          end
        end
        default: ifg_cnt <= ifg_cnt + 1'b1;
      endcase
    end
  end
endmodule

// File: tb/tb_rmii_tx_scheduler.sv
// tb/tb_rmii_tx_scheduler.sv - scoreboard bench for rmii_tx_scheduler
// Wire monitor decodes frames and compares them against queued expectations.
module tb_rmii_tx_scheduler;
  localparam int NR = 2;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic          rst;
  logic [NR-1:0] req_valid, req_last, req_ready, grant;
  logic [8*NR-1:0] req_data;
  logic          busy, underrun, truncated, tx_en, tx0, tx1;

  logic       s_valid, s_last, s_ready, s_grant;
  logic [7:0] s_data;
  logic       s_busy, s_underrun, s_truncated, s_tx_en, s_tx0, s_tx1;

  rmii_tx_scheduler #(.NUM_REQ(NR), .IFG_CLKS(48), .MAX_FRAME_BYTES(4)) dut (
    .clk_50MHz(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .grant(grant), .busy(busy),
    .underrun(underrun), .truncated(truncated), .TX_EN(tx_en), .TX0(tx0), .TX1(tx1)
  );

  rmii_tx_scheduler #(.NUM_REQ(1), .IFG_CLKS(48), .MAX_FRAME_BYTES(1522)) dut_single (
    .clk_50MHz(clk), .rst(rst), .req_valid(s_valid), .req_data(s_data),
    .req_last(s_last), .req_ready(s_ready), .grant(s_grant), .busy(s_busy),
    .underrun(s_underrun), .truncated(s_truncated), .TX_EN(s_tx_en), .TX0(s_tx0), .TX1(s_tx1)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, want);
    end
  endtask

  typedef struct {
    int          owner;
    int          nbytes;
    logic [31:0] data;
    int          und;
    int          trn;
    int          ready;
    int          gap;
  } exp_t;

  exp_t       exp_q[$];
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [NR-1:0] acc;
  logic       mon_en = 1'b0;

  task automatic push_byte(input int who, input logic [7:0] d, input logic last);
    if (who == 0) q0.push_back({last, d});
    else q1.push_back({last, d});
  endtask

  task automatic expect_frame(input int owner, input int nbytes, input logic [31:0] data,
                              input int und, input int trn, input int ready, input int gap);
    exp_t e;
    e.owner = owner; e.nbytes = nbytes; e.data = data;
    e.und = und; e.trn = trn; e.ready = ready; e.gap = gap;
    exp_q.push_back(e);
  endtask

  // Requester model: a byte leaves its queue only when the DUT really accepted it.
  initial begin
    req_valid = '0; req_data = '0; req_last = '0;
    forever begin
      @(negedge clk);
      acc = req_ready & req_valid & {NR{~rst}};
      @(posedge clk);
      #1;
      if (acc[0] && q0.size() > 0) void'(q0.pop_front());
      if (acc[1] && q1.size() > 0) void'(q1.pop_front());
      req_valid[0]  = (q0.size() > 0);
      req_data[7:0] = (q0.size() > 0) ? q0[0][7:0] : 8'h00;
      req_last[0]   = (q0.size() > 0) ? q0[0][8] : 1'b0;
      req_valid[1]  = (q1.size() > 0);
      req_data[15:8] = (q1.size() > 0) ? q1[0][7:0] : 8'h00;
      req_last[1]   = (q1.size() > 0) ? q1[0][8] : 1'b0;
    end
  end

  logic          in_frame = 1'b0;
  int            f_len, f_ready, f_first_ready, f_und, f_trn, f_gap, f_busy_gap;
  int            low_cnt = 0, busy_low = 0;
  logic [NR-1:0] f_owner;
  logic [1:0]    dib[0:63];

  task automatic check_frame();
    exp_t        e;
    logic [31:0] word;
    logic [7:0]  b;
    logic        pre_ok;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_frame actual_len=%0d expected=none", f_len);
      return;
    end
    e = exp_q.pop_front();
    pre_ok = (f_len >= 32);
    for (int i = 0; i < 31; i++) if (dib[i] != 2'b01) pre_ok = 1'b0;
    if (dib[31] != 2'b11) pre_ok = 1'b0;
    word = '0;
    for (int k = 0; k < e.nbytes && k < 4; k++) begin
      if (32 + 4*k + 3 < f_len) begin
        b = {dib[32+4*k+3], dib[32+4*k+2], dib[32+4*k+1], dib[32+4*k]};
        word = word | (32'(b) << (8*k));
      end
    end
    check("owner", int'(f_owner), 1 << e.owner);
    check("frame_len", f_len, 32 + 4*e.nbytes);
    check("preamble", int'(pre_ok), 1);
    check("data", int'(word), int'(e.data));
    check("ready_count", f_ready, e.ready);
    check("first_ready", f_first_ready, 31);
    check("underrun_pulses", f_und, e.und);
    check("truncated_pulses", f_trn, e.trn);
    if (e.gap > 0) begin
      check("gap_len", f_gap, e.gap);
      check("gap_busy", f_busy_gap, e.gap - 1);
    end
  endtask

  initial begin
    wait (mon_en);
    forever begin
      @(negedge clk);
      check("grant_onehot0", int'($onehot0(grant)), 1);
      check("ready_in_grant", int'(req_ready & ~grant), 0);
      check("ready_needs_txen", int'((req_ready != '0) && !tx_en), 0);
      if (!tx_en) check("tx_idle_zero", int'({tx1, tx0}), 0);
      if (tx_en) begin
        if (!in_frame) begin
          in_frame = 1'b1; f_len = 0; f_ready = 0; f_first_ready = -1;
          f_und = 0; f_trn = 0; f_owner = grant; f_gap = low_cnt; f_busy_gap = busy_low;
        end
        if (f_len < 64) dib[f_len] = {tx1, tx0};
        if (req_ready != '0) begin
          if (f_first_ready < 0) f_first_ready = f_len;
          f_ready++;
        end
        f_und += int'(underrun);
        f_trn += int'(truncated);
        f_len++;
      end else if (in_frame) begin
        f_und += int'(underrun);
        f_trn += int'(truncated);
        in_frame = 1'b0;
        check("grant_clear_at_end", int'(grant), 0);
        check_frame();
        low_cnt  = 1;
        busy_low = int'(busy);
      end else begin
        check("stray_underrun", int'(underrun), 0);
        check("stray_truncated", int'(truncated), 0);
        low_cnt++;
        busy_low += int'(busy);
      end
    end
  end

  // Single-requester instance: frames of one byte must repeat with a fixed gap.
  int s_hi = 0, s_lo = 0, s_nf = 0;
  initial begin
    wait (mon_en);
    forever begin
      @(negedge clk);
      if (s_tx_en) begin
        if (s_hi == 0 && s_nf > 0 && s_nf <= 3) check("single_gap", s_lo, 49);
        s_hi++;
      end else begin
        if (s_hi > 0) begin
          if (s_nf < 3) begin
            check("single_len", s_hi, 36);
            check("single_no_underrun", int'(s_underrun), 0);
          end
          s_nf++;
          s_hi = 0;
          s_lo = 0;
        end
        s_lo++;
      end
    end
  end

  task automatic wait_done(input int budget);
    int t = 0;
    while (exp_q.size() > 0 && t < budget) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL timeout pending_frames=%0d expected=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    int t;
    rst = 1'b1;
    s_valid = 1'b1; s_data = 8'h96; s_last = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_en", int'(tx_en), 0);
    check("rst_tx", int'({tx1, tx0}), 0);
    check("rst_grant", int'(grant), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_underrun", int'(underrun), 0);
    check("rst_truncated", int'(truncated), 0);
    check("rst_ready", int'(req_ready), 0);
    rst = 1'b0;
    mon_en = 1'b1;

    // Two-byte frame from requester 0 (pointer starts at NUM_REQ-1).
    @(negedge clk);
    expect_frame(0, 2, 32'h0000_3CA5, 0, 0, 2, 0);
    push_byte(0, 8'hA5, 1'b0);
    push_byte(0, 8'h3C, 1'b1);
    wait_done(2000);

    // Both requesters loaded with one-byte frames; pointer now at 0 so requester 1 leads.
    @(negedge clk);
    expect_frame(1, 1, 32'h0000_0021, 0, 0, 1, 0);
    expect_frame(0, 1, 32'h0000_0010, 0, 0, 1, 49);
    expect_frame(1, 1, 32'h0000_0023, 0, 0, 1, 49);
    expect_frame(0, 1, 32'h0000_0012, 0, 0, 1, 49);
    push_byte(0, 8'h10, 1'b1);
    push_byte(0, 8'h12, 1'b1);
    push_byte(1, 8'h21, 1'b1);
    push_byte(1, 8'h23, 1'b1);
    wait_done(2000);

    // Requester 1 runs dry at its second ready cycle.
    @(negedge clk);
    expect_frame(1, 1, 32'h0000_005A, 1, 0, 2, 0);
    push_byte(1, 8'h5A, 1'b0);
    wait_done(2000);

    // Six bytes without last against a 4-byte limit: truncated frame, then the leftover underruns.
    @(negedge clk);
    expect_frame(0, 4, 32'h0403_0201, 0, 1, 4, 0);
    expect_frame(0, 2, 32'h0000_0605, 1, 0, 3, 49);
    for (int i = 1; i <= 6; i++) push_byte(0, 8'(i), 1'b0);
    wait_done(2000);

    // Reset during the first data byte; the remaining bytes form the next frame.
    @(negedge clk);
    expect_frame(0, 1, 32'h0000_0011, 0, 0, 2, 0);
    expect_frame(0, 2, 32'h0000_3322, 0, 0, 2, 1);
    push_byte(0, 8'h11, 1'b0);
    push_byte(0, 8'h22, 1'b0);
    push_byte(0, 8'h33, 1'b1);
    t = 0;
    do begin
      @(posedge clk);
      #1;
      t++;
    end while (!tx_en && t < 2000);
    check("reset_test_frame_start", int'(tx_en), 1);
    repeat (35) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_tx_en", int'(tx_en), 0);
    check("midrst_grant", int'(grant), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_underrun", int'(underrun), 0);
    @(posedge clk);
    #1;
    check("postrst_grant", int'(grant), 1);
    check("postrst_tx_en", int'(tx_en), 1);
    wait_done(2000);
    check("sources_drained", q0.size() + q1.size(), 0);
    check("single_frames_seen", int'(s_nf >= 3), 1);

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
